alu_multiciclo: RTL and testbench
=================================

// Module: alu_multiciclo
// PURPOSE
//  Parametrised, registered successor to the datapath ALU. Adds XOR, shifts and SLTU.
//  Adds iterative signed/unsigned MULT/DIV writing dedicated HI/LO registers.
//  Sits in the EX stage; the control unit stalls the pipeline on busy.
//  Uses a start/busy/done handshake.
// PARAMETERS
//  WIDTH   32  operand/result width (>=8, power of 2)
//  CTRL_W  4   width of entradaControl
// PORTS
//  clk             in   1        single clock, rising edge
//  reset           in   1        synchronous, active-high
//  start           in   1        operation request, sampled when busy=0
//  entradaA        in   WIDTH    operand A (rs)
//  entradaB        in   WIDTH    operand B (rt/imm)
//  entradaControl  in   CTRL_W   operation code
//  busy            out  1        mul/div in progress, new start ignored
//  done            out  1        1-cycle pulse, ALUresult/Zero valid
//  ALUresult       out  WIDTH    registered result
//  Zero            out  1        registered, 1 iff ALUresult==0
//  hi              out  WIDTH    HI register (remainder / product upper half)
//  lo              out  WIDTH    LO register (quotient / product lower half)
// BEHAVIOUR
//  Reset: busy=0, done=0, ALUresult=0, Zero=1, hi=0, lo=0. Reset mid-mul/div aborts; no done.
//  Codes:
//    0 AND, 1 OR, 2 ADD, 3 SLTU, 4 XOR, 5 SLL, 6 SUB, 7 SLT, 8 SRL, 9 SRA,
//    10 MULT, 11 MULTU, 12 NOR, 13 DIV, 14 DIVU, 15 reserved.
//  Shifts: A shifted by B[log2(WIDTH)-1:0]; SRA sign-fills from A[WIDTH-1].
//  NOR is bitwise ~(A|B). ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
//  SLT is signed; SLTU is unsigned. Result is 1 or 0, zero-extended.
//  Reserved code: ALUresult=0, Zero=1, done pulses.
//  Timing: cycle 0 = cycle in which start=1 and busy=0 are sampled.
//  Single-cycle ops: ALUresult/Zero updated at end of cycle 0; done=1 in cycle 1; busy stays 0.
//  MULT/MULTU/DIV/DIVU:
//    Operands latched at end of cycle 0.
//    busy=1 in cycles 1..WIDTH+1 (WIDTH iterations plus 1 sign-fixup cycle).
//    hi/lo and ALUresult=lo written at end of cycle WIDTH+1; done=1 in cycle WIDTH+2, busy=0.
//  Back-to-back: start may be asserted in the same cycle done=1 (busy=0) and is accepted.
//  start while busy=1 is ignored, with no effect on the operation in flight.
//  ALUresult/Zero/hi/lo hold their values between operations; done is 0 otherwise.
//  Signed mul/div: computed on magnitudes, then fixed up.
//    Product sign = A^B sign. Quotient sign = A^B sign. Remainder takes the sign of A.
//    Division truncates toward zero.
//  Divide by zero: lo = all ones, hi = A (unsigned dividend bits); done still after full latency.
//  Most-negative / -1 (DIV): lo = most-negative value, hi = 0; no trap.
//  Single-cycle ops never modify hi/lo.
//  FSM: IDLE -(start & mul/div code)-> ITER (count 0..WIDTH-1) -> FIX -> IDLE.
//    done is registered on the FIX->IDLE transition.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (ALU_AND..ALU_DIVU, ALU_RSVD).
//    It also holds the FSM state encoding, so the control unit and testbench share one source.
//  One sub-module, muldiv_iter:
//    Shift-add multiplier and restoring divider sharing one WIDTH+1-bit adder and the counter.
//    Ports: start, is_div, is_signed, a, b, busy, hi, lo, fin.
//  The top level holds the single-cycle ALU mux, result/Zero registers and handshake.
// TESTING
//  1. Single-cycle ops, WIDTH=32:
//     ADD 0x7FFFFFFF+1 -> ALUresult=0x80000000, Zero=0, done in cycle 1.
//     SUB 5-5 -> 0, Zero=1.
//     NOR 0,0 -> 0xFFFFFFFF.
//  2. Compare and shift:
//     SLT A=-1, B=1 -> 1. SLTU same operands -> 0.
//     SRA A=0x80000000, B=4 -> 0xF8000000. SLL A=1, B=31 -> 0x80000000.
//  3. MULT:
//     A=-3, B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly in cycle 34, busy=1 in cycles 1..33.
//     MULTU 0xFFFFFFFF^2 -> hi=0xFFFFFFFE, lo=1.
//  4. DIV:
//     A=-7, B=2 -> lo=-3, hi=-1.
//     DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
//     DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  5. Handshake:
//     start held high during DIV -> second op starts only in the cycle done=1, then completes.
//     Prior hi/lo are unchanged by an intervening ADD.
//  6. reset=1 in cycle 10 of MULT -> next cycle busy=0, done=0, hi=lo=0, ALUresult=0, Zero=1.
//     No done ever appears for the aborted op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and the
// mul/div sequencer state encoding, used by the RTL and the testbench.
package alu_pkg;

    // Operation codes carried on entradaControl
    localparam int ALU_AND   = 0;
    localparam int ALU_OR    = 1;
    localparam int ALU_ADD   = 2;
    localparam int ALU_SLTU  = 3;
    localparam int ALU_XOR   = 4;
    localparam int ALU_SLL   = 5;
    localparam int ALU_SUB   = 6;
    localparam int ALU_SLT   = 7;
    localparam int ALU_SRL   = 8;
    localparam int ALU_SRA   = 9;
    localparam int ALU_MULT  = 10;
    localparam int ALU_MULTU = 11;
    localparam int ALU_NOR   = 12;
    localparam int ALU_DIV   = 13;
    localparam int ALU_DIVU  = 14;
    localparam int ALU_RSVD  = 15;

    // Iterative mul/div sequencer: idle, WIDTH iterations, one sign fix-up cycle
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_ITER = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiplier / divider. Signed operations run on magnitudes and
// the signs are restored in a final fix-up cycle. The shift-add multiplier
// and the restoring divider share one WIDTH+1-bit adder and the counter.
// hi/lo are the final results and are only meaningful while fin=1.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             fin
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic               is_div_q, is_div_d;
    logic               neg_main_q, neg_main_d;
    logic               neg_rem_q, neg_rem_d;
    logic               b_zero_q, b_zero_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_x, add_y;
    logic               add_cin;
    logic [WIDTH+1:0]   add_sum;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes for signed operations; the most-negative value maps to 2^(WIDTH-1)
    always_comb begin
        mag_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // Shared adder: accumulate multiplicand for multiply, trial-subtract divisor for divide
    always_comb begin
        if (is_div_q) begin
            add_x   = {hi_q, lo_q[WIDTH-1]};
            add_y   = ~{1'b0, mcand_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, hi_q};
            add_y   = lo_q[0] ? {1'b0, mcand_q} : '0;
            add_cin = 1'b0;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(add_cin);
    end

    // Sequencer next state: load operands, iterate WIDTH times, then fix up signs
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mcand_d    = mcand_q;
        raw_a_d    = raw_a_q;
        is_div_d   = is_div_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        b_zero_d   = b_zero_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d    = MD_ITER;
                    count_d    = '0;
                    hi_d       = '0;
                    is_div_d   = is_div;
                    raw_a_d    = a;
                    b_zero_d   = (b == '0);
                    neg_main_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d  = is_signed & a[WIDTH-1];
                    if (is_div) begin
                        lo_d    = mag_a;
                        mcand_d = mag_b;
                    end else begin
                        lo_d    = mag_b;
                        mcand_d = mag_a;
                    end
                end
            end
            MD_ITER: begin
                if (is_div_q) begin
                    if (add_sum[WIDTH+1]) begin
                        hi_d = add_sum[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_d = add_sum[WIDTH:1];
                    lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH-1)) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // Sequencer and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MD_IDLE;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mcand_q    <= '0;
            raw_a_q    <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            b_zero_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mcand_q    <= mcand_d;
            raw_a_q    <= raw_a_d;
            is_div_q   <= is_div_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            b_zero_q   <= b_zero_d;
        end
    end

    // Sign fix-up and divide-by-zero override applied to the raw magnitude results
    always_comb begin
        prod = {hi_q, lo_q};
        if (is_div_q) begin
            if (b_zero_q) begin
                hi = raw_a_q;
                lo = '1;
            end else begin
                hi = neg_rem_q  ? (~hi_q + 1'b1) : hi_q;
                lo = neg_main_q ? (~lo_q + 1'b1) : lo_q;
            end
        end else begin
            if (neg_main_q) begin
                prod = ~{hi_q, lo_q} + 1'b1;
            end
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end
    end

    assign busy = (state_q != MD_IDLE);
    assign fin  = (state_q == MD_FIX);

endmodule

// File: rtl/alu_multiciclo.sv
// Registered EX-stage ALU with a start/busy/done handshake. Single-cycle
// operations complete one cycle after start; MULT/MULTU/DIV/DIVU are handed
// to muldiv_iter and write HI/LO plus ALUresult=LO when it finishes.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  entradaA,
    input  logic [WIDTH-1:0]  entradaB,
    input  logic [CTRL_W-1:0] entradaControl,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  ALUresult,
    output logic              Zero,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_out;
    logic             is_md;
    logic             md_div;
    logic             md_signed;
    logic             accept;
    logic             md_busy;
    logic             md_fin;
    logic [WIDTH-1:0] md_hi, md_lo;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    assign shamt  = entradaB[SH_W-1:0];
    assign accept = start & ~md_busy;

    // Decode the operation: single-cycle result, or which mul/div flavour to launch
    always_comb begin
        alu_out   = '0;
        is_md     = 1'b0;
        md_div    = 1'b0;
        md_signed = 1'b0;
        case (entradaControl)
            CTRL_W'(ALU_AND):   alu_out = entradaA & entradaB;
            CTRL_W'(ALU_OR):    alu_out = entradaA | entradaB;
            CTRL_W'(ALU_ADD):   alu_out = entradaA + entradaB;
            CTRL_W'(ALU_SLTU):  alu_out = WIDTH'(entradaA < entradaB);
            CTRL_W'(ALU_XOR):   alu_out = entradaA ^ entradaB;
            CTRL_W'(ALU_SLL):   alu_out = entradaA << shamt;
            CTRL_W'(ALU_SUB):   alu_out = entradaA - entradaB;
            CTRL_W'(ALU_SLT):   alu_out = WIDTH'($signed(entradaA) < $signed(entradaB));
            CTRL_W'(ALU_SRL):   alu_out = entradaA >> shamt;
            CTRL_W'(ALU_SRA):   alu_out = $signed(entradaA) >>> shamt;
            CTRL_W'(ALU_NOR):   alu_out = ~(entradaA | entradaB);
            CTRL_W'(ALU_MULT):  begin
                is_md     = 1'b1;
                md_signed = 1'b1;
            end
            CTRL_W'(ALU_MULTU): begin
                is_md     = 1'b1;
            end
            CTRL_W'(ALU_DIV):   begin
                is_md     = 1'b1;
                md_div    = 1'b1;
                md_signed = 1'b1;
            end
            CTRL_W'(ALU_DIVU):  begin
                is_md     = 1'b1;
                md_div    = 1'b1;
            end
            default:            alu_out = '0;
        endcase
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .start     (accept & is_md),
        .is_div    (md_div),
        .is_signed (md_signed),
        .a         (entradaA),
        .b         (entradaB),
        .busy      (md_busy),
        .hi        (md_hi),
        .lo        (md_lo),
        .fin       (md_fin)
    );

    // Result registers: written by an accepted single-cycle op or by mul/div completion
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        if (md_fin) begin
            hi_d     = md_hi;
            lo_d     = md_lo;
            result_d = md_lo;
            zero_d   = (md_lo == '0);
            done_d   = 1'b1;
        end else if (accept && !is_md) begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            done_d   = 1'b1;
        end
    end

    // Output registers with synchronous reset; done is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy      = md_busy;
    assign done      = done_q;
    assign ALUresult = result_q;
    assign Zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Testbench for alu_multiciclo: directed cases, handshake/reset scenarios and
// randomized operations, all checked by a queue-based scoreboard whose
// expectations come from an arithmetic reference model.
module tb_alu_multiciclo;
    import alu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  entradaA;
    logic [WIDTH-1:0]  entradaB;
    logic [CTRL_W-1:0] entradaControl;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  ALUresult;
    logic              Zero;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [31:0] hi;
        logic [31:0] lo;
        int          op;
    } exp_t;

    exp_t        expQ[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_hi    = '0;
    logic [31:0] model_lo    = '0;

    alu_multiciclo #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .entradaA       (entradaA),
        .entradaB       (entradaB),
        .entradaControl (entradaControl),
        .busy           (busy),
        .done           (done),
        .ALUresult      (ALUresult),
        .Zero           (Zero),
        .hi             (hi),
        .lo             (lo)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Global time limit so the run always ends
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s", name);
    endtask

    // Reference model: plain integer arithmetic; mul/div update the modelled HI/LO
    function automatic exp_t modelOp(input int op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] r;
        logic [63:0] p;
        longint      sa, sb;
        int          q, rm;
        int unsigned sh;
        sh = int'(b & 32'd31);
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_ADD:  r = a + b;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << sh;
            ALU_SUB:  r = a - b;
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = 32'(sa >>> sh);
            ALU_NOR:  r = ~(a | b);
            ALU_MULT: begin
                p = 64'(sa * sb);
                model_hi = p[63:32];
                model_lo = p[31:0];
                r = model_lo;
            end
            ALU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                model_hi = p[63:32];
                model_lo = p[31:0];
                r = model_lo;
            end
            ALU_DIV: begin
                if (b == 32'd0) begin
                    model_lo = 32'hFFFF_FFFF;
                    model_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    model_lo = 32'h8000_0000;
                    model_hi = 32'd0;
                end else begin
                    q  = $signed(a) / $signed(b);
                    rm = $signed(a) % $signed(b);
                    model_lo = q;
                    model_hi = rm;
                end
                r = model_lo;
            end
            ALU_DIVU: begin
                if (b == 32'd0) begin
                    model_lo = 32'hFFFF_FFFF;
                    model_hi = a;
                end else begin
                    model_lo = a / b;
                    model_hi = a % b;
                end
                r = model_lo;
            end
            default:  r = '0;
        endcase
        e.res  = r;
        e.zero = (r == 32'd0);
        e.hi   = model_hi;
        e.lo   = model_lo;
        e.op   = op;
        return e;
    endfunction

    // Called at a falling edge: wait for busy=0, present one request for one cycle
    task automatic applyStimulus(input int op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy !== 1'b0) reportFail("busy wait timeout");
        entradaControl = CTRL_W'(op);
        entradaA       = a;
        entradaB       = b;
        start          = 1'b1;
        expQ.push_back(modelOp(op, a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) at falling edges until done is seen
    task automatic waitDone(input string name);
        int guard = 0;
        while (done !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (done !== 1'b1) reportFail({name, " done timeout"});
    endtask

    // Directed case with literal expected values
    task automatic runDirected(input string name, input int op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input logic [31:0] expHi, input logic [31:0] expLo,
                               input bit checkHiLo);
        applyStimulus(op, a, b);
        waitDone(name);
        checkOutput({name, " result"}, ALUresult, expRes);
        if (checkHiLo) begin
            checkOutput({name, " hi"}, hi, expHi);
            checkOutput({name, " lo"}, lo, expLo);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: every done pulse pops the oldest expectation and compares it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (expQ.size() == 0) begin
                    reportFail("unexpected done with empty scoreboard");
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("op%0d result", e.op), ALUresult, e.res);
                    checkOutput($sformatf("op%0d zero", e.op), {31'd0, Zero}, {31'd0, e.zero});
                    checkOutput($sformatf("op%0d hi", e.op), hi, e.hi);
                    checkOutput($sformatf("op%0d lo", e.op), lo, e.lo);
                end
            end
        end
    end

    // Main sequence
    initial begin
        int bad;
        int guard;
        reset          = 1'b1;
        start          = 1'b0;
        entradaA       = '0;
        entradaB       = '0;
        entradaControl = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset result", ALUresult, 32'd0);
        checkOutput("reset zero", {31'd0, Zero}, 32'd1);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);

        $display("[TB] single-cycle operations");
        applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        checkOutput("add done cycle1", {30'd0, done, busy}, 32'd2);
        checkOutput("add result", ALUresult, 32'h8000_0000);
        checkOutput("add zero", {31'd0, Zero}, 32'd0);
        runDirected("sub", ALU_SUB, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("sub zero", {31'd0, Zero}, 32'd1);
        runDirected("nor", ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
        runDirected("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0);
        runDirected("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0);
        runDirected("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'd0, 32'd0, 1'b0);
        runDirected("sll", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 32'd0, 32'd0, 1'b0);
        runDirected("rsvd", ALU_RSVD, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("rsvd zero", {31'd0, Zero}, 32'd1);

        $display("[TB] MULT latency");
        applyStimulus(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
        bad = 0;
        for (int k = 1; k <= 33; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        checkOutput("mult busy window cycles 1..33", 32'(bad), 32'd0);
        checkOutput("mult done in cycle 34", {30'd0, done, busy}, 32'd2);
        checkOutput("mult hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult lo", lo, 32'hFFFF_FFEB);
        runDirected("multu", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 32'd1, 1'b1);

        $display("[TB] DIV cases");
        runDirected("div -7/2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        runDirected("divu 7/0", ALU_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 1'b1);
        runDirected("div min/-1", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b1);

        $display("[TB] start held during DIV");
        entradaControl = CTRL_W'(ALU_DIV);
        entradaA       = 32'd100;
        entradaB       = 32'd7;
        start          = 1'b1;
        expQ.push_back(modelOp(ALU_DIV, 32'd100, 32'd7));
        @(negedge clk);
        entradaControl = CTRL_W'(ALU_ADD);
        entradaA       = 32'd3;
        entradaB       = 32'd4;
        guard = 0;
        bad   = 0;
        while (busy === 1'b1 && guard < 100) begin
            if (done !== 1'b0) bad++;
            @(negedge clk);
            guard++;
        end
        checkOutput("held start no early done", 32'(bad), 32'd0);
        checkOutput("held start div done with busy low", {30'd0, done, busy}, 32'd2);
        expQ.push_back(modelOp(ALU_ADD, 32'd3, 32'd4));
        @(negedge clk);
        start = 1'b0;
        checkOutput("held start add done", {31'd0, done}, 32'd1);
        checkOutput("held start add result", ALUresult, 32'd7);
        checkOutput("hi kept across add", hi, 32'd2);
        checkOutput("lo kept across add", lo, 32'd14);

        $display("[TB] reset during MULT");
        applyStimulus(ALU_MULT, 32'd12345, 32'd678);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        expQ.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort result", ALUresult, 32'd0);
        checkOutput("abort zero", {31'd0, Zero}, 32'd1);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        repeat (45) @(negedge clk);

        $display("[TB] randomized operations");
        for (int i = 0; i < 150; i++) begin
            applyStimulus(int'($urandom_range(0, 15)), pickOperand(), pickOperand());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        guard = 0;
        while ((expQ.size() != 0 || busy !== 1'b0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() != 0) reportFail($sformatf("drain: %0d expected results never seen", expQ.size()));
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
